// File: rtl/dbg_cap_reader.sv
// Read-side engine for the dual-bank debug capture RAM: walks the circular buffer
// oldest-first and streams words out. Optional DBG_CAP_RD_WORD_CNT_EN adds rd_word_cnt.
module dbg_cap_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int RAM_READ_DELAY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_start,
  input  logic                  rd_abort,
  input  logic                  capture_done,
  input  logic [ADDR_WIDTH-1:0] read_start_addr,
  input  logic [ADDR_WIDTH-1:0] capture_max_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [1:0]            fsm_state
`ifdef DBG_CAP_RD_WORD_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]   rd_word_cnt
`endif
);

  localparam int FIFO_DEPTH = RAM_READ_DELAY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH:0]   ONE_W    = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = 1;
  localparam logic [CNT_W:0]        DEPTH_W  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   max_lat;
  logic [ADDR_WIDTH:0]     issue_cnt;
  logic [ADDR_WIDTH:0]     rem_cnt;
  logic [RAM_READ_DELAY-1:0] vld_sr;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  logic             busy_st;
  logic             abort_now;
  logic             start_legal;
  logic             start_ok;
  logic             start_bad;
  logic [CNT_W:0]   outstanding;
  logic             credit_ok;
  logic             push;
  logic             pop;

  assign busy_st     = (state != IDLE);
  assign abort_now   = rd_abort && busy_st;
  assign start_legal = capture_done && (read_start_addr <= capture_max_addr);
  // Abort wins over a same-cycle start, so a start paired with abort does nothing.
  assign start_ok    = (state == IDLE) && rd_start && !rd_abort && start_legal;
  assign start_bad   = (state == IDLE) && rd_start && !rd_abort && !start_legal;

  // Credit: every issued-but-unpopped word owns a FIFO slot, so pushes can never overflow.
  assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = (outstanding < DEPTH_W);
  assign ram_rd_en   = (state == READ) && (issue_cnt != '0) && credit_ok && !rd_abort;

  assign push = vld_sr[RAM_READ_DELAY-1] && !abort_now;

  // Output handshake: a word transfers on a cycle with out_vld && out_rdy; while out_vld
  // is high and out_rdy low, out_data and out_last hold until the transfer happens.
  assign out_vld  = (fifo_count != '0);
  assign out_data = out_vld ? fifo_mem[rd_ptr] : '0;
  assign out_last = out_vld && (rem_cnt == ONE_W);
  assign pop      = out_vld && out_rdy && !abort_now;

  assign fsm_state = state;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= IDLE;
      ram_raddr <= '0;
      max_lat   <= '0;
      issue_cnt <= '0;
      rem_cnt   <= '0;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      rd_err  <= start_bad;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= READ;
            ram_raddr <= read_start_addr;
            max_lat   <= capture_max_addr;
            issue_cnt <= {1'b0, capture_max_addr} + ONE_W;
            rem_cnt   <= {1'b0, capture_max_addr} + ONE_W;
            rd_busy   <= 1'b1;
          end
        end
        READ, DRAIN: begin
          if (rd_abort) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rem_cnt   <= '0;
            rd_busy   <= 1'b0;
          end else begin
            if (ram_rd_en) begin
              ram_raddr <= (ram_raddr == max_lat) ? '0 : ram_raddr + ONE_A;
              issue_cnt <= issue_cnt - ONE_W;
              if (issue_cnt == ONE_W) state <= DRAIN;
            end
            if (pop) begin
              rem_cnt <= rem_cnt - ONE_W;
              if (rem_cnt == ONE_W) begin
                state   <= IDLE;
                rd_busy <= 1'b0;
                rd_done <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return tagging and FIFO bookkeeping; an abort discards everything still in flight.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      vld_sr     <= '0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (abort_now) begin
      vld_sr     <= '0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      vld_sr[0] <= ram_rd_en;
      for (int i = 1; i < RAM_READ_DELAY; i++) vld_sr[i] <= vld_sr[i-1];
      in_flight  <= in_flight + CNT_W'(ram_rd_en) - CNT_W'(vld_sr[RAM_READ_DELAY-1]);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

`ifdef DBG_CAP_RD_WORD_CNT_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_word_cnt <= '0;
    end else if (start_ok || abort_now) begin
      rd_word_cnt <= '0;
    end else if (pop) begin
      rd_word_cnt <= rd_word_cnt + ONE_W;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(push && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_dbg_cap_reader.sv
// Randomized bench for dbg_cap_reader: a queue-based readout model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_dbg_cap_reader;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int RD_DELAY = 3;
  localparam int DEPTH = RD_DELAY + 2;

  logic          clk;
  logic          rst_n;
  logic          rd_start;
  logic          rd_abort;
  logic          capture_done;
  logic [AW-1:0] read_start_addr;
  logic [AW-1:0] capture_max_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic          out_last;
  logic          rd_busy;
  logic          rd_done;
  logic          rd_err;
  logic [1:0]    fsm_state;
`ifdef DBG_CAP_RD_WORD_CNT_EN
  logic [AW:0]   rd_word_cnt;
`endif

  dbg_cap_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_READ_DELAY(RD_DELAY)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_start(rd_start), .rd_abort(rd_abort),
    .capture_done(capture_done), .read_start_addr(read_start_addr),
    .capture_max_addr(capture_max_addr), .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
    .fsm_state(fsm_state)
`ifdef DBG_CAP_RD_WORD_CNT_EN
    , .rd_word_cnt(rd_word_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] rpipe [RD_DELAY];
  always @(posedge clk) begin
    rpipe[0] <= mem[ram_raddr];
    for (int i = 1; i < RD_DELAY; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RD_DELAY-1];

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] acc_q[$];
  bit   m_busy, m_done, m_err;
  int   m_wcnt;
  int   n_iss, n_acc;
  int   done_cnt, err_cnt;
  bit   stall_prev;
  logic [DW-1:0] prev_data;
  bit   lat_mode, first_seen;
  int   t_start, t_first, t_last;
  int   rdy_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_wcnt = 0;
    stall_prev = 0;
    exp_q.delete(); addr_q.delete();
  endtask

  // One compare process: check this cycle, then advance the model to the next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("rd_busy", rd_busy, m_busy);
      chk("rd_done", rd_done, m_done);
      chk("rd_err", rd_err, m_err);
      if (rd_done) done_cnt++;
      if (rd_err) err_cnt++;
`ifdef DBG_CAP_RD_WORD_CNT_EN
      chk("rd_word_cnt", rd_word_cnt, m_wcnt);
`endif
      if (!m_busy) begin
        chk("idle_out_vld", out_vld, 0);
        chk("idle_ram_rd_en", ram_rd_en, 0);
      end else begin
        if (stall_prev) begin
          chk("stall_vld", out_vld, 1);
          chk("stall_data", out_data, prev_data);
        end
        if (out_vld) begin
          if (!first_seen) begin
            first_seen = 1;
            t_first = cyc;
            if (lat_mode) chk("latency", cyc - t_start, 2 + RD_DELAY);
          end
          if (exp_q.size() == 0) chk("extra_word", 1, 0);
          else begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_last", out_last, exp_q.size() == 1);
          end
        end
        if (ram_rd_en) begin
          if (addr_q.size() == 0) chk("extra_read", 1, 0);
          else chk("ram_raddr", ram_raddr, addr_q.pop_front());
        end
        chk("credit", (n_iss + int'(ram_rd_en) - n_acc) <= DEPTH, 1);
      end

      m_done = 0;
      m_err = 0;
      stall_prev = m_busy && out_vld && !out_rdy && !rd_abort;
      prev_data = out_data;
      if (m_busy && ram_rd_en) n_iss++;
      if (!m_busy) begin
        if (rd_start && !rd_abort) begin
          if (capture_done && read_start_addr <= capture_max_addr) begin
            int n;
            n = int'(capture_max_addr) + 1;
            exp_q.delete(); addr_q.delete(); acc_q.delete();
            for (int i = 0; i < n; i++) begin
              logic [AW-1:0] a;
              a = AW'((int'(read_start_addr) + i) % n);
              addr_q.push_back(a);
              exp_q.push_back(mem[a]);
            end
            m_busy = 1; m_wcnt = 0; n_iss = 0; n_acc = 0;
            t_start = cyc; first_seen = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (rd_abort) begin
        m_busy = 0; m_wcnt = 0;
        exp_q.delete(); addr_q.delete();
      end else if (out_vld && out_rdy && exp_q.size() != 0) begin
        acc_q.push_back(out_data);
        void'(exp_q.pop_front());
        n_acc++; m_wcnt++;
        if (exp_q.size() == 0) begin
          m_busy = 0; m_done = 1; t_last = cyc;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_rdy = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((rd_busy || m_busy) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) chk("timeout_idle", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input int s, input int m, input int pct, input bit lat);
    read_start_addr = AW'(s);
    capture_max_addr = AW'(m);
    rdy_pct = pct;
    lat_mode = lat;
    done_cnt = 0;
    pulse_start();
    wait_idle(30000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [DW-1:0] basic_exp [8];
    rst_n = 1'b0; rd_start = 1'b0; rd_abort = 1'b0; capture_done = 1'b0;
    read_start_addr = '0; capture_max_addr = '0;
    for (int a = 0; a < 8192; a++) mem[a] = DW'(a);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fsm_state", fsm_state, 0);
    rst_n = 1'b1;
    capture_done = 1'b1;

    // basic readout with wrap, latency and throughput
    run(5, 7, 100, 1);
    basic_exp = '{32'd5, 32'd6, 32'd7, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    chk("basic_count", acc_q.size(), 8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("basic_word", acc_q[i], basic_exp[i]);
    chk("basic_issued", n_iss, 8);
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_throughput", t_last - t_first, 7);

    for (int a = 0; a < 8192; a++) mem[a] = $urandom;

    // backpressure
    run(0, 15, 50, 0);
    chk("bp_count", n_acc, 16);
    chk("bp_done_pulses", done_cnt, 1);

    // illegal starts
    err_cnt = 0;
    capture_done = 1'b0;
    read_start_addr = 0; capture_max_addr = 7;
    pulse_start();
    repeat (3) @(posedge clk);
    capture_done = 1'b1;
    read_start_addr = 9; capture_max_addr = 8;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 chk("illegal_err_pulses", err_cnt, 2);
    chk("illegal_busy", rd_busy, 0);

    // abort + start together in idle, abort alone in idle: nothing happens
    read_start_addr = 2; capture_max_addr = 4;
    @(posedge clk); #1 rd_start = 1'b1; rd_abort = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    @(posedge clk); #1 rd_abort = 1'b0;
    chk("abort_start_busy", rd_busy, 0);

    // single word
    run(0, 0, 100, 1);
    chk("single_count", acc_q.size(), 1);
    if (acc_q.size() != 0) chk("single_word", acc_q[0], mem[0]);
    chk("single_issued", n_iss, 1);
    chk("single_done", done_cnt, 1);

    // abort after 100 words, then a clean full restart
    read_start_addr = 1234; capture_max_addr = 8191; rdy_pct = 70; lat_mode = 0;
    done_cnt = 0;
    pulse_start();
    k = 0;
    while (n_acc < 100 && k < 2000) begin @(posedge clk); #1; k++; end
    if (k >= 2000) chk("timeout_abort", 1, 0);
    rd_abort = 1'b1;
    @(posedge clk); #1 rd_abort = 1'b0;
    chk("abort_out_vld", out_vld, 0);
    chk("abort_rd_busy", rd_busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
`ifdef DBG_CAP_RD_WORD_CNT_EN
    chk("abort_word_cnt", rd_word_cnt, 0);
`endif
    run(1234, 8191, 90, 0);
    chk("full_count", n_acc, 8192);
    chk("full_done", done_cnt, 1);
    if (acc_q.size() != 0) chk("full_first", acc_q[0], mem[1234]);
`ifdef DBG_CAP_RD_WORD_CNT_EN
    chk("full_word_cnt", rd_word_cnt, 8192);
`endif

    // randomized runs with ignored starts, capture_done drops and occasional aborts
    for (int r = 0; r < 8; r++) begin
      int m;
      m = $urandom_range(0, 63);
      read_start_addr = AW'($urandom_range(0, m));
      capture_max_addr = AW'(m);
      rdy_pct = $urandom_range(30, 100);
      lat_mode = 0;
      pulse_start();
      k = 0;
      while ((rd_busy || m_busy) && k < 5000) begin
        @(posedge clk); #1;
        k++;
        rd_start = ($urandom_range(0, 99) < 3);
        rd_abort = (r % 3 == 2) && ($urandom_range(0, 99) == 0);
        capture_done = ($urandom_range(0, 9) != 0);
      end
      if (k >= 5000) chk("timeout_rand", 1, 0);
      rd_start = 1'b0; rd_abort = 1'b0; capture_done = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end

    // asynchronous reset mid-readout
    read_start_addr = 3; capture_max_addr = 63; rdy_pct = 60;
    pulse_start();
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_rd_busy", rd_busy, 0);
    chk("arst_ram_rd_en", ram_rd_en, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_fsm_state", fsm_state, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(10, 20, 100, 1);
    chk("post_rst_count", n_acc, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_cap_reader.md
Name: dbg_cap_reader

Overview:
- Read-side engine for the dual-bank debug capture RAM.
- After a capture completes, it walks the circular capture buffer in chronological order, starting at read_start_addr and wrapping at capture_max_addr.
- It issues RAM reads with a fixed RAM_READ_DELAY latency and streams 32-bit words out over a valid/ready interface with backpressure.
- Sits in the rd_clk domain, between the RAM read ports and the host/DMA readout path.

Parameters:
- DATA_WIDTH, 32, RAM read data / output word width (two 16-bit banks concatenated).
- ADDR_WIDTH, 13, capture buffer address width.
- RAM_READ_DELAY, 1, cycles from ram_rd_en to valid ram_rdata (1..4).

Ports:
- rd_clk  in  1  read clock.
- rd_rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  single-cycle pulse; begin readout.
- rd_abort  in  1  single-cycle pulse; cancel readout.
- capture_done  in  1  level; capture complete (already synchronized to rd_clk).
- read_start_addr  in  ADDR_WIDTH  oldest sample address.
- capture_max_addr  in  ADDR_WIDTH  last valid buffer address.
- ram_rd_en  out  1  RAM read enable.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid RAM_READ_DELAY cycles after ram_rd_en.
- out_data  out  DATA_WIDTH  streamed word.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  downstream ready.
- out_last  out  1  marks final word, qualified by out_vld.
- rd_busy  out  1  readout in progress.
- rd_done  out  1  single-cycle pulse when the last word is accepted.
- rd_err  out  1  single-cycle pulse on an illegal start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states: IDLE, READ, DRAIN.
- IDLE to READ:
  - Condition: rd_start=1, capture_done=1 and read_start_addr<=capture_max_addr.
  - Latch both addresses.
  - Load issue_cnt = rem_cnt = capture_max_addr+1, computed ADDR_WIDTH+1 bits wide.
  - Set rd_busy=1 on the next cycle.
- rd_start in IDLE with capture_done=0, or read_start_addr>capture_max_addr:
  - rd_err pulses the next cycle.
  - Stay in IDLE; no RAM reads are issued.
- rd_start while busy: ignored, no error.
- READ, issue condition:
  - ram_rd_en=1 when issue_cnt!=0 and (in_flight + fifo_count) < FIFO_DEPTH.
  - FIFO_DEPTH = RAM_READ_DELAY+2 (internal).
- READ, address sequence:
  - ram_raddr starts at read_start_addr and increments by 1 per issued read.
  - After issuing capture_max_addr, the next address is 0.
- READ, counting:
  - issue_cnt decrements per issue.
  - When issue_cnt reaches 0, go to DRAIN.
- Read data path:
  - A RAM_READ_DELAY-deep valid shift register tags returning data.
  - Returning words are pushed into the FIFO; the credit rule guarantees the FIFO never overflows.
  - A push with FIFO full is a design error, checked by assertion.
- Output:
  - out_vld = FIFO not empty; out_data = FIFO head.
  - A word is popped when out_vld & out_rdy.
  - Data is held stable while out_vld=1 and out_rdy=0.
- rem_cnt decrements on each pop. out_last=1 when out_vld=1 and rem_cnt==1.
- DRAIN to IDLE:
  - Transition on the pop with rem_cnt==1.
  - rd_done pulses 1 cycle after that pop; rd_busy drops in the same cycle as rd_done.
- Minimum latency: rd_start to first out_vld = 2+RAM_READ_DELAY cycles, with out_rdy held high.
- Throughput: one word per cycle sustained with out_rdy=1.
- Edge case, capture_max_addr=0: exactly one word, read from address 0, with out_last on it.
- Edge case, read_start_addr=0: no wrap occurs.
- rd_abort in READ or DRAIN:
  - Next cycle: return to IDLE, flush the FIFO, ignore in-flight returns, deassert out_vld and rd_busy.
  - No rd_done pulse.
- rd_abort in IDLE: ignored.
- rd_abort and rd_start in the same cycle: abort wins.
- capture_done falling mid-readout: ignored, readout continues.
- Asynchronous reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: DBG_CAP_RD_WORD_CNT_EN.
- When defined:
  - Adds output port rd_word_cnt [ADDR_WIDTH:0].
  - Counts words accepted downstream in the current or last readout.
  - Clears to 0 on a legal start and on abort; holds its value after done.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Basic readout: capture_max_addr=7, read_start_addr=5, out_rdy=1, RAM preloaded with data=addr -> out_data sequence 5,6,7,0,1,2,3,4; out_last on the word 4; one rd_done pulse; 8 reads issued in total.
- Backpressure: capture_max_addr=15, start 0, out_rdy toggled at 50% random, RAM_READ_DELAY=3 -> in-order 0..15, no data lost or duplicated, FIFO never exceeds 5 entries, out_data stable while stalled.
- Illegal start: rd_start with capture_done=0 -> rd_err pulse, ram_rd_en stays 0. Then capture_done=1, read_start_addr=9, capture_max_addr=8 -> rd_err pulse again.
- Single word: capture_max_addr=0 -> one read at address 0, out_vld with out_last=1 on the same word, then rd_done.
- Abort: capture_max_addr=8191, abort after 100 accepted words -> next cycle out_vld=0, rd_busy=0, no rd_done. A new rd_start then restarts cleanly from read_start_addr.
- Word count (macro defined): full 8192-word readout -> rd_word_cnt=8192. Abort after 100 words -> rd_word_cnt=0.
